nanov_periph: RTL

NANOV_PERIPH -- requirements
Module: nanov_periph

---
 rtl/nanov_periph_if.sv | 20 ++
 rtl/nanov_periph.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nanov_periph_if.sv
// nanov_periph_if: CPU <-> peripheral serial-result bus.
// Carries the address/store-data word with its two strobes, the load-consumed
// strobe and the returned load word. master = CPU side, slave = peripheral side.
interface nanov_periph_if;
    logic [31:0] data_out;        // address or bit-reversed store data from the CPU
    logic        store_addr_out;  // strobe: data_out holds a load/store address
    logic        store_data_out;  // strobe: data_out holds bit-reversed store data
    logic        data_in_read;    // strobe: CPU consumed ext_data_in
    logic [31:0] ext_data_in;     // load data returned to the CPU

    modport master (
        output data_out, store_addr_out, store_data_out, data_in_read,
        input  ext_data_in
    );

    modport slave (
        input  data_out, store_addr_out, store_data_out, data_in_read,
        output ext_data_in
    );
endinterface

// File: rtl/nanov_periph.sv
// nanov_periph: memory-mapped GPIO + UART at 0x1000_0000 for the serial CPU.
// Ports: clk/rstn (sync, active-low), bus (nanov_periph_if.slave), gpio_out/gpio_in,
// uart_tx/uart_rx. Load data snapshots one clock after the address strobe; no backpressure
// (a UART_DATA store while the transmitter is busy is dropped).
module nanov_periph #(
    parameter int CLK_DIV = 104
) (
    input  logic                 clk,
    input  logic                 rstn,
    nanov_periph_if.slave        bus,
    output logic [7:0]           gpio_out,
    input  logic [7:0]           gpio_in,
    output logic                 uart_tx,
    input  logic                 uart_rx
);

    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    function automatic logic is_hit(input logic [31:2] a);
        return (a[31:24] == 8'h10) && (a[23:4] == 20'h0);
    endfunction

    // Word address only; the byte offset never affects decode.
    logic [31:2] addr_q;
    logic [31:0] ext_q;
    logic [7:0]  gpio_out_q, gpio_s1_q, gpio_s2_q;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_overrun_q;

    uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        rx_done;

    // Store data arrives bit-reversed; only the low byte of the reversed word is used.
    logic [7:0] wdata;
    always_comb begin
        wdata = '0;
        for (int i = 0; i < 8; i++) wdata[i] = bus.data_out[31-i];
    end

    logic       tx_busy, wr_hit, tx_start, ack_hit;
    logic [1:0] wr_sel, rd_sel;
    logic [31:0] rd_dat;

    assign tx_busy  = (tx_state_q != S_IDLE);
    assign wr_sel   = addr_q[3:2];
    assign wr_hit   = bus.store_data_out && is_hit(addr_q);
    assign tx_start = wr_hit && (wr_sel == 2'd2) && !tx_busy;
    assign ack_hit  = bus.data_in_read && is_hit(addr_q);

    // Load snapshot decodes the address being strobed in, not the old latched one.
    assign rd_sel = bus.data_out[3:2];
    always_comb begin
        rd_dat = '0;
        if (is_hit(bus.data_out[31:2])) begin
            case (rd_sel)
                2'd0: rd_dat = {24'h0, gpio_out_q};
                2'd1: rd_dat = {24'h0, gpio_s2_q};
                2'd2: rd_dat = {24'h0, rx_data_q};
                2'd3: rd_dat = {29'h0, rx_overrun_q, rx_valid_q, tx_busy};
            endcase
        end
    end

    // UART transmitter next state / line output.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        uart_tx    = 1'b1;
        case (tx_state_q)
            S_IDLE: begin
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = wdata;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end else tx_cnt_d = tx_cnt_q + 16'd1;
            end
            S_DATA: begin
                uart_tx = tx_shift_q[0];
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else tx_cnt_d = tx_cnt_q + 16'd1;
            end
            S_STOP: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else tx_cnt_d = tx_cnt_q + 16'd1;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // UART receiver: rx_s2_q is the synchronized line, rx_s3_q its previous value.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-start re-check; a high line means the edge was a glitch.
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else rx_cnt_d = rx_cnt_q + 16'd1;
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else rx_cnt_d = rx_cnt_q + 16'd1;
            end
            S_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_done    = rx_s2_q;   // framing error drops the byte silently
                end else rx_cnt_d = rx_cnt_q + 16'd1;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q       <= '0;
            ext_q        <= '0;
            gpio_out_q   <= '0;
            gpio_s1_q    <= '0;
            gpio_s2_q    <= '0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
        end else begin
            gpio_s1_q  <= gpio_in;
            gpio_s2_q  <= gpio_s1_q;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;

            if (bus.store_addr_out) begin
                addr_q <= bus.data_out[31:2];
                ext_q  <= rd_dat;
            end
            if (wr_hit && (wr_sel == 2'd0)) gpio_out_q <= wdata;

            // A completing byte beats a same-cycle consume of rx_valid.
            if (rx_done) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                if (rx_valid_q) rx_overrun_q <= 1'b1;
            end else if (ack_hit && (wr_sel == 2'd2)) begin
                rx_valid_q <= 1'b0;
            end
            if (ack_hit && (wr_sel == 2'd3) && !(rx_done && rx_valid_q)) rx_overrun_q <= 1'b0;
        end
    end

    assign gpio_out        = gpio_out_q;
    assign bus.ext_data_in = ext_q;

endmodule
